// File: rtl/wave_phase_gen.sv
// DDS phase accumulator driving saw/square/triangle samples aligned with a sine BRAM lookup.
// Latency: tick in cycle n -> all four samples and sample_valid in cycle n+2+RD_LAT; one sample per tick.
// Backpressure: none on the sample path; ftw_ready stays low while an accepted tuning word awaits its first tick.
module wave_phase_gen #(
   parameter int PHASE_W = 24,
   parameter int ADDR_W  = 8,
   parameter int RD_LAT  = 1,
   parameter int DIV     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [PHASE_W-1:0] ftw_in,
   input  logic               ftw_valid,
   output logic               ftw_ready,
   input  logic [7:0]         duty,
   output logic [ADDR_W-1:0]  bram_addr,
   output logic               bram_en,
   input  logic [7:0]         bram_dout,
   output logic [7:0]         saw_out,
   output logic [7:0]         sq_out,
   output logic [7:0]         tri_out,
   output logic [7:0]         sin_out,
   output logic               sample_valid
);

   localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   typedef enum logic {FTW_IDLE, FTW_PENDING} ftw_state_t;

   ftw_state_t         state_q;
   ftw_state_t         state_d;
   logic               ftw_capture;
   logic               ftw_load;
   logic [PHASE_W-1:0] ftw_shadow;
   logic [PHASE_W-1:0] ftw_active;
   logic [PHASE_W-1:0] ftw_step;
   logic [PHASE_W-1:0] phase_q;
   logic [CNT_W-1:0]   div_cnt;
   logic               tick;
   logic [7:0]         duty_q;
   logic [7:0]         p;
   logic [7:0]         saw_c;
   logic [7:0]         sq_c;
   logic [7:0]         tri_c;
   logic [RD_LAT-1:0]  vld_pipe;
   logic [23:0]        wav_pipe [RD_LAT];

   assign tick      = enable && (div_cnt == CNT_MAX);
   assign bram_addr = phase_q[PHASE_W-1 -: ADDR_W];
   assign p         = phase_q[PHASE_W-1 -: 8];

   // Sample divider: free-runs 0..DIV-1 while enabled, freezes otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (enable) begin
         div_cnt <= (div_cnt == CNT_MAX) ? '0 : div_cnt + 1'b1;
      end
   end

   // Tuning-word handshake state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FTW_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Handshake next state: accept one word, then hold it until the next tick applies it.
   always_comb begin
      state_d     = state_q;
      ftw_ready   = 1'b0;
      ftw_capture = 1'b0;
      ftw_load    = 1'b0;
      case (state_q)
         FTW_IDLE: begin
            ftw_ready = 1'b1;
            if (ftw_valid) begin
               ftw_capture = 1'b1;
               state_d     = FTW_PENDING;
            end
         end
         FTW_PENDING: begin
            if (tick) begin
               ftw_load = 1'b1;
               state_d  = FTW_IDLE;
            end
         end
         default: state_d = FTW_IDLE;
      endcase
   end

   // The tick that retires a pending word already steps by it, so the change is phase-continuous.
   assign ftw_step = ftw_load ? ftw_shadow : ftw_active;

   // Shadow/active tuning words, phase accumulator, duty snapshot and BRAM read strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ftw_shadow <= '0;
         ftw_active <= '0;
         phase_q    <= '0;
         duty_q     <= '0;
         bram_en    <= 1'b0;
      end else begin
         if (ftw_capture) ftw_shadow <= ftw_in;
         if (ftw_load)    ftw_active <= ftw_shadow;
         if (tick) begin
            phase_q <= phase_q + ftw_step;
            duty_q  <= duty;
         end
         bram_en <= tick;
      end
   end

   // Wave shaping from the updated phase; triangle folds the upper half back down.
   always_comb begin
      saw_c = p;
      sq_c  = (p < duty_q) ? 8'hFF : 8'h00;
      tri_c = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
   end

   // Delay line matching the BRAM read latency so all four samples land together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) wav_pipe[i] <= '0;
      end else begin
         vld_pipe[0] <= bram_en;
         wav_pipe[0] <= {saw_c, sq_c, tri_c};
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            wav_pipe[i] <= wav_pipe[i-1];
         end
      end
   end

   // Output register: loads only on a completed sample, holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         saw_out      <= '0;
         sq_out       <= '0;
         tri_out      <= '0;
         sin_out      <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= vld_pipe[RD_LAT-1];
         if (vld_pipe[RD_LAT-1]) begin
            {saw_out, sq_out, tri_out} <= wav_pipe[RD_LAT-1];
            sin_out <= bram_dout;
         end
      end
   end

endmodule

// File: tb/tb_wave_phase_gen.sv
// Directed bench for wave_phase_gen: default instance plus a DIV=3 / RD_LAT=2 instance.
// Latency: checks the n+2+RD_LAT tick-to-sample timing on both instances.
// Backpressure: exercises the tuning-word valid/ready hold while disabled.
module tb_wave_phase_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;

   logic        enable = 1'b0, ftw_valid = 1'b0, ftw_ready, bram_en, sample_valid;
   logic [23:0] ftw_in = '0;
   logic [7:0]  duty = '0, bram_addr, bram_dout = '0;
   logic [7:0]  saw_out, sq_out, tri_out, sin_out;

   logic        enable_b = 1'b0, ftw_valid_b = 1'b0, ftw_ready_b, bram_en_b, sample_valid_b;
   logic [23:0] ftw_in_b = '0;
   logic [7:0]  duty_b = '0, bram_addr_b, bram_dout_b = '0, mem_s1_b = '0;
   logic [7:0]  saw_out_b, sq_out_b, tri_out_b, sin_out_b;

   always #5 clk = ~clk;

   wave_phase_gen u_dut (
      .clk(clk), .rst(rst), .enable(enable), .ftw_in(ftw_in), .ftw_valid(ftw_valid),
      .ftw_ready(ftw_ready), .duty(duty), .bram_addr(bram_addr), .bram_en(bram_en),
      .bram_dout(bram_dout), .saw_out(saw_out), .sq_out(sq_out), .tri_out(tri_out),
      .sin_out(sin_out), .sample_valid(sample_valid)
   );

   wave_phase_gen #(.PHASE_W(24), .ADDR_W(8), .RD_LAT(2), .DIV(3)) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable_b), .ftw_in(ftw_in_b), .ftw_valid(ftw_valid_b),
      .ftw_ready(ftw_ready_b), .duty(duty_b), .bram_addr(bram_addr_b), .bram_en(bram_en_b),
      .bram_dout(bram_dout_b), .saw_out(saw_out_b), .sq_out(sq_out_b), .tri_out(tri_out_b),
      .sin_out(sin_out_b), .sample_valid(sample_valid_b)
   );

   function automatic logic [7:0] sine_f(input logic [7:0] a);
      return {a[3:0], a[7:4]} ^ 8'h3C;
   endfunction

   function automatic logic [7:0] tri_f(input int v);
      if (v < 128) return 8'(2 * v);
      return 8'(2 * (255 - v));
   endfunction

   // One-cycle registered sine table.
   always @(posedge clk) if (bram_en) bram_dout <= sine_f(bram_addr);

   // Two-cycle registered sine table.
   always @(posedge clk) begin
      if (bram_en_b) mem_s1_b <= sine_f(bram_addr_b);
      bram_dout_b <= mem_s1_b;
   end

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic load_ftw(input logic [23:0] v);
      ftw_in = v; ftw_valid = 1'b1;
      @(posedge clk); #1;
      ftw_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3 rst = 1'b0;
      #1;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", sample_valid); end
      checks++; if ({saw_out, sq_out, tri_out, sin_out} !== 32'h0) begin errors++; $display("FAIL rst_waves got %0h want 0", {saw_out, sq_out, tri_out, sin_out}); end
      checks++; if (ftw_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h want 1", ftw_ready); end
      checks++; if ({bram_en, bram_addr} !== 9'h0) begin errors++; $display("FAIL rst_bram got %0h want 0", {bram_en, bram_addr}); end
      checks++; if ({ftw_ready_b, sample_valid_b} !== 2'b10) begin errors++; $display("FAIL rst_b got %0h want 2", {ftw_ready_b, sample_valid_b}); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_handshake();
      enable = 1'b0; duty = 8'h00;
      ftw_in = 24'h020000; ftw_valid = 1'b1;
      #1;
      checks++; if (ftw_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_idle got %0h want 1", ftw_ready); end
      @(posedge clk); #1;
      checks++; if (ftw_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_pend got %0h want 0", ftw_ready); end
      ftw_in = 24'h070000;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({ftw_ready, sample_valid} !== 2'b00) begin errors++; $display("FAIL hs_hold got %0h want 0", {ftw_ready, sample_valid}); end
      ftw_valid = 1'b0;
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      checks++; if (ftw_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_back got %0h want 1", ftw_ready); end
      checks++; if ({bram_en, bram_addr} !== 9'h102) begin errors++; $display("FAIL hs_bram got %0h want 102", {bram_en, bram_addr}); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL hs_early1 got %0h want 0", sample_valid); end
      @(posedge clk); #1;
      checks++; if ({bram_en, sample_valid} !== 2'b00) begin errors++; $display("FAIL hs_early2 got %0h want 0", {bram_en, sample_valid}); end
      @(posedge clk); #1;
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL hs_latency got %0h want 1", sample_valid); end
      checks++; if ({saw_out, sq_out, tri_out, sin_out} !== {8'h02, 8'h00, 8'h04, sine_f(8'h02)}) begin
         errors++; $display("FAIL hs_sample got %0h want %0h", {saw_out, sq_out, tri_out, sin_out}, {8'h02, 8'h00, 8'h04, sine_f(8'h02)}); end
      @(posedge clk); #1;
      checks++; if ({sample_valid, saw_out} !== 9'h002) begin errors++; $display("FAIL hs_hold_out got %0h want 002", {sample_valid, saw_out}); end
   endtask

   task automatic test_ramp();
      int got = 0, extra = 0, expn = 1;
      logic started = 1'b0;
      logic [7:0] e_saw, t127 = 8'hAA, t128 = 8'hAA, t0 = 8'hAA;
      do_reset();
      duty = 8'd64;
      load_ftw(24'h010000);
      enable = 1'b1;
      for (int cyc = 0; cyc < 400 && got < 256; cyc++) begin
         @(posedge clk); #1;
         if (started) begin
            checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ramp_gap got %0h want 1 at pulse %0d", sample_valid, got); end
         end
         if (sample_valid === 1'b1) begin
            started = 1'b1;
            e_saw = 8'(expn);
            checks++; if (saw_out !== e_saw) begin errors++; $display("FAIL ramp_saw got %0h want %0h", saw_out, e_saw); end
            checks++; if (tri_out !== tri_f(int'(e_saw))) begin errors++; $display("FAIL ramp_tri got %0h want %0h", tri_out, tri_f(int'(e_saw))); end
            checks++; if (sq_out !== ((e_saw < 8'd64) ? 8'hFF : 8'h00)) begin errors++; $display("FAIL ramp_sq got %0h at p %0h", sq_out, e_saw); end
            checks++; if (sin_out !== sine_f(e_saw)) begin errors++; $display("FAIL ramp_sin got %0h want %0h", sin_out, sine_f(e_saw)); end
            if (e_saw == 8'd127) t127 = tri_out;
            if (e_saw == 8'd128) t128 = tri_out;
            if (e_saw == 8'd0)   t0   = tri_out;
            got++; expn++;
         end
      end
      enable = 1'b0;
      checks++; if (got !== 256) begin errors++; $display("FAIL ramp_count got %0d want 256", got); end
      checks++; if ({t127, t128, t0} !== 24'hFEFE00) begin errors++; $display("FAIL ramp_tri_edges got %0h want fefe00", {t127, t128, t0}); end
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(posedge clk); #1;
         if (sample_valid === 1'b1) begin
            e_saw = 8'(expn);
            checks++; if (saw_out !== e_saw) begin errors++; $display("FAIL drain_saw got %0h want %0h", saw_out, e_saw); end
            extra++; expn++;
         end
      end
      checks++; if (extra !== 2) begin errors++; $display("FAIL drain_count got %0d want 2", extra); end
      checks++; if (saw_out !== 8'h02) begin errors++; $display("FAIL drain_hold got %0h want 02", saw_out); end
   endtask

   task automatic test_duty_zero();
      int got = 0;
      do_reset();
      duty = 8'd0;
      load_ftw(24'h100000);
      enable = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk); #1;
         if (sample_valid === 1'b1) begin
            got++;
            checks++; if (sq_out !== 8'h00) begin errors++; $display("FAIL sq0 got %0h want 0 at p %0h", sq_out, saw_out); end
            checks++; if (saw_out !== 8'(16 * got)) begin errors++; $display("FAIL sq0_saw got %0h want %0h", saw_out, 8'(16 * got)); end
         end
      end
      enable = 1'b0;
      repeat (6) @(posedge clk);
      #1 duty = 8'hFF;
      repeat (4) @(posedge clk);
      #1;
      checks++; if ({sample_valid, sq_out} !== 9'h000) begin errors++; $display("FAIL sq_duty_hold got %0h want 0", {sample_valid, sq_out}); end
   endtask

   task automatic test_wrap();
      logic seen;
      do_reset();
      duty = 8'h80;
      load_ftw(24'hFFFFF0);
      enable = 1'b1; @(posedge clk); #1; enable = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
         @(posedge clk); #1;
         if (sample_valid === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL wrap_pre timeout got 0 want 1"); end
      checks++; if ({saw_out, sq_out, tri_out} !== 24'hFF0000) begin errors++; $display("FAIL wrap_pre got %0h want ff0000", {saw_out, sq_out, tri_out}); end
      load_ftw(24'h000020);
      enable = 1'b1; @(posedge clk); #1; enable = 1'b0;
      checks++; if ({bram_en, bram_addr} !== 9'h100) begin errors++; $display("FAIL wrap_addr got %0h want 100", {bram_en, bram_addr}); end
      seen = 1'b0;
      for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
         @(posedge clk); #1;
         if (sample_valid === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL wrap_post timeout got 0 want 1"); end
      checks++; if ({saw_out, sq_out, tri_out, sin_out} !== {8'h00, 8'hFF, 8'h00, sine_f(8'h00)}) begin
         errors++; $display("FAIL wrap_post got %0h want %0h", {saw_out, sq_out, tri_out, sin_out}, {8'h00, 8'hFF, 8'h00, sine_f(8'h00)}); end
   endtask

   task automatic test_mid_reset();
      duty = 8'hFF;
      load_ftw(24'h050000);
      enable = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0; enable = 1'b0;
      #1;
      checks++; if ({sample_valid, bram_en, bram_addr} !== 10'h0) begin errors++; $display("FAIL mrst_ctrl got %0h want 0", {sample_valid, bram_en, bram_addr}); end
      checks++; if ({saw_out, sq_out, tri_out, sin_out} !== 32'h0) begin errors++; $display("FAIL mrst_waves got %0h want 0", {saw_out, sq_out, tri_out, sin_out}); end
      checks++; if (ftw_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got %0h want 1", ftw_ready); end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(posedge clk); #1;
         checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL mrst_flush got %0h want 0", sample_valid); end
      end
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      @(posedge clk); #1;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL mrst_early got %0h want 0", sample_valid); end
      @(posedge clk); #1;
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL mrst_first got %0h want 1", sample_valid); end
      checks++; if (saw_out !== 8'h00) begin errors++; $display("FAIL mrst_saw got %0h want 0", saw_out); end
   endtask

   task automatic test_align();
      int got = 0, last = 0;
      logic [7:0] addr_q[$];
      logic [7:0] a, e;
      do_reset();
      ftw_in_b = 24'h030000; ftw_valid_b = 1'b1;
      @(posedge clk); #1;
      ftw_valid_b = 1'b0;
      checks++; if (ftw_ready_b !== 1'b0) begin errors++; $display("FAIL al_ready got %0h want 0", ftw_ready_b); end
      enable_b = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(posedge clk); #1;
         if (bram_en_b === 1'b1) addr_q.push_back(bram_addr_b);
         if (sample_valid_b === 1'b1) begin
            if (got == 0) begin
               checks++; if (cyc !== 6) begin errors++; $display("FAIL al_latency got %0d want 6", cyc); end
            end else begin
               checks++; if (cyc - last !== 3) begin errors++; $display("FAIL al_spacing got %0d want 3", cyc - last); end
            end
            e = 8'(3 * (got + 1));
            checks++; if (saw_out_b !== e) begin errors++; $display("FAIL al_saw got %0h want %0h", saw_out_b, e); end
            if (addr_q.size() > 0) begin
               a = addr_q.pop_front();
               checks++; if ({saw_out_b, sin_out_b} !== {a, sine_f(a)}) begin errors++; $display("FAIL al_sin got %0h want %0h", {saw_out_b, sin_out_b}, {a, sine_f(a)}); end
            end else begin
               checks++; errors++; $display("FAIL al_noaddr got empty want address");
            end
            last = cyc; got++;
         end
      end
      enable_b = 1'b0;
      checks++; if (got !== 19) begin errors++; $display("FAIL al_count got %0d want 19", got); end
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_ramp();
      test_duty_zero();
      test_wrap();
      test_mid_reset();
      test_align();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wave_phase_gen.md
WAVE_PHASE_GEN -- requirements
Module: wave_phase_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 24, phase accumulator width (>=16).
REQ-002 SHALL have parameter ADDR_W, default 8, sine BRAM address width (<=PHASE_W).
REQ-003 SHALL have parameter RD_LAT, default 1, BRAM read latency in clk cycles (1..3).
REQ-004 SHALL have parameter DIV, default 1, clk cycles per sample tick (>=1).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  input  1  run/hold for the sample divider and the accumulator.
REQ-008 SHALL have port ftw_in  input  PHASE_W  frequency tuning word.
REQ-009 SHALL have port ftw_valid  input  1  ftw_in offered.
REQ-010 SHALL have port ftw_ready  output  1  ftw_in accepted when valid&ready.
REQ-011 SHALL have port duty  input  8  square-wave high threshold.
REQ-012 SHALL have port bram_addr  output  ADDR_W  sine table address.
REQ-013 SHALL have port bram_en  output  1  sine table read strobe.
REQ-014 SHALL have port bram_dout  input  8  sine table data.
REQ-015 SHALL have ports saw_out, sq_out, tri_out, sin_out  output  8 each  waveform samples for the downstream selector.
REQ-016 SHALL have port sample_valid  output  1  one-cycle pulse when all four samples update.

Function
REQ-017 Divider SHALL count 0..DIV-1 while enable=1, hold while enable=0; tick = enable & (count==DIV-1); DIV=1 gives tick every enabled cycle.
REQ-018 On tick, phase SHALL update to phase+ftw_active mod 2^PHASE_W; with no tick, phase holds.
REQ-019 FTW FSM: IDLE (ftw_ready=1) -> PENDING on ftw_valid&ftw_ready, ftw_in captured to shadow; PENDING (ftw_ready=0) -> IDLE on next tick.
REQ-020 On a tick in PENDING, ftw_active SHALL load shadow and the same tick SHALL use the shadow value (phase-continuous change, no phase reset).
REQ-021 ftw_valid in PENDING SHALL be ignored; PENDING SHALL persist indefinitely while enable=0.
REQ-022 Let p = phase[PHASE_W-1:PHASE_W-8] after the update: saw = p; sq = 255 if p<duty else 0 (duty=0 -> always 0); tri = 2p for p<128, 2*(255-p) for p>=128, 8-bit.
REQ-023 bram_addr SHALL equal phase[PHASE_W-1:PHASE_W-ADDR_W] from the phase register; bram_en SHALL be high exactly the cycle after each tick.
REQ-024 bram_dout SHALL be sampled RD_LAT cycles after bram_en; saw/sq/tri SHALL be delayed so all four outputs register on the same edge.
REQ-025 Latency: tick in cycle n -> outputs updated and sample_valid=1 in cycle n+2+RD_LAT; throughput one sample per tick.
REQ-026 sq uses duty sampled at the tick cycle; duty changes between ticks SHALL NOT alter held outputs.
REQ-027 enable falling SHALL NOT stall in-flight samples; they complete and pulse sample_valid.
REQ-028 Outputs SHALL hold their last values between sample_valid pulses.

Reset
REQ-029 rst=0 SHALL immediately force: phase, ftw_active, shadow, divider, pipeline, all wave outputs, bram_en, sample_valid = 0; FSM = IDLE, ftw_ready = 1.
REQ-030 Reset mid-operation SHALL discard in-flight samples; no sample_valid until a post-reset tick completes the pipeline.

Verification
REQ-031 Reset: assert rst=0 mid-run -> all outputs 0, ftw_ready=1 in same cycle, no sample_valid for 2+RD_LAT cycles after first post-reset tick.
REQ-032 Ramp: PHASE_W=24, DIV=1, RD_LAT=1, load ftw=0x010000, enable -> saw 1,2,3,...,255,0 on consecutive sample_valid pulses; tri=254 at p=127 and p=128, tri=0 at p=0.
REQ-033 Square: duty=64 -> sq_out=255 for p 0..63, 0 for p 64..255; duty=0 -> sq_out constant 0.
REQ-034 Handshake: enable=0, offer ftw=0x020000 -> accepted, ftw_ready=0; second offer ignored; enable=1 -> first tick applies 0x020000, ftw_ready returns 1 next cycle.
REQ-035 Wrap: phase=0xFFFFF0, ftw=0x000020 -> next phase 0x000010, saw_out 0.
REQ-036 Alignment: BRAM model RD_LAT=2, DIV=3 -> sin_out equals model[bram_addr of the same tick] on the pulse where saw_out reflects that tick; sample_valid every 3rd cycle.
